serial_crc_accumulator: RTL and testbench
=========================================

// Module: serial_crc_accumulator
// PURPOSE
//  Consumes the serial bit stream driven by the XOR stage (out1), one bit per cycle.
//  Folds the stream into an N-bit CRC using an XOR-feedback LFSR, MSB-first.
//  Frames are delimited by sof/eof. The final CRC is presented on a valid/ready output port.
//  Sits directly downstream of the XOR cell as the first clocked stage of the datapath.
// PARAMETERS
//  WIDTH    8      CRC register width, in bits
//  POLY     8'h07  generator polynomial; the implicit x^WIDTH term is omitted
//  INIT     8'h00  CRC register value loaded at sof
//  MAX_BITS 1024   maximum bits per frame; exceeding it sets the error flag
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous, active-low reset
//  in_bit     in   1      serial data bit (the XOR stage output)
//  in_valid   in   1      in_bit is valid this cycle
//  in_sof     in   1      qualifies in_bit as the first bit of a frame
//  in_eof     in   1      qualifies in_bit as the last bit of a frame
//  in_ready   out  1      block accepts a bit this cycle
//  crc_out    out  WIDTH  final CRC of the completed frame
//  bit_count  out  16     bits accepted in the completed frame (saturates)
//  frame_err  out  1      completed frame overflowed MAX_BITS
//  out_valid  out  1      crc_out, bit_count and frame_err are valid
//  out_ready  in   1      downstream consumes the result
// BEHAVIOUR
//  Reset (async assert, sync deassert by the system): state=IDLE, crc=INIT, all outputs 0.
//  Accept condition: a bit is accepted when in_valid & in_ready.
//  Update per accepted bit:
//    fb  = crc[WIDTH-1] ^ in_bit
//    crc <= {crc[WIDTH-2:0],1'b0} ^ (fb ? POLY : 0)
//    When in_sof, the update starts from INIT, not from the current crc.
//  States:
//   IDLE: in_ready=1. Bits without in_sof are dropped.
//         Accepted sof bit -> RUN, with cnt=1 and crc updated from INIT.
//         sof & eof in the same cycle -> DONE directly (a 1-bit frame).
//   RUN:  in_ready=1. Each accepted bit updates crc and increments cnt.
//         Accepted eof -> DONE.
//         Accepted sof mid-frame: abandon the current frame and restart from INIT with cnt=1.
//         The abandoned frame produces no output.
//   DONE: in_ready=0. out_valid=1. crc_out, bit_count and frame_err stay stable until
//         out_valid & out_ready, then -> IDLE.
//  Result latency: out_valid rises on the first clock edge after the eof bit is accepted.
//  Input while busy: an input offered while in_ready=0 is not consumed; the source must hold it.
//  Counter: cnt saturates at 16'hFFFF, never wraps. err sets when cnt would exceed MAX_BITS.
//  After overflow: err stays set for the rest of the frame, and the CRC keeps accumulating.
//  frame_err is a copy of err, valid only while out_valid=1.
//  Output registers: crc_out and bit_count are registered at the DONE transition,
//   not taken combinationally from the LFSR.
//  Reset mid-frame or mid-DONE: the pending frame and result are discarded; the block is in
//   IDLE with all outputs 0 on the next cycle.
//  in_valid=0 in RUN: crc and cnt hold; there is no timeout.
// STRUCTURE
//  Shared package: state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10), the CRC-8 POLY and INIT
//   constants, and the counter width (16).
//  Sub-module: crc_lfsr_step, purely combinational. Inputs crc, bit, load_init; output next crc.
//  Top level: FSM, bit counter, error flag and output registers only.
// TESTING
//  1. Frame 0x31 (8 bits, MSB-first) -> crc_out=8'h97, bit_count=8, frame_err=0.
//  2. 1-bit frame, in_bit=1, sof=eof=1 -> crc_out=8'h07, bit_count=1, out_valid on the next edge.
//  3. Frame 0x00 with out_ready held low for 5 cycles -> crc_out=8'h00 held stable;
//     in_ready=0 throughout; IDLE one cycle after out_ready=1.
//  4. Send 0xFF, then sof mid-frame at bit 4, then 0x31 -> a single result only:
//     crc_out=8'h97, bit_count=8.
//  5. Frame of MAX_BITS+1 bits -> frame_err=1, bit_count=MAX_BITS+1.
//  6. Assert rst_n=0 at bit 3 of a frame, then send a full 0x31 frame -> outputs 0 during reset;
//     the clean frame yields 8'h97.

Source files
------------

// File: rtl/serial_crc_accumulator_pkg.sv
// serial_crc_accumulator_pkg
//   Shared definitions for the serial CRC accumulator: FSM state encoding,
//   default CRC-8 generator and seed, frame-length limit and bit counter width.
//   No ports (package).
package serial_crc_accumulator_pkg;

  localparam int          CRC_WIDTH     = 8;
  localparam logic [7:0]  CRC_POLY      = 8'h07;  // x^8 term implicit
  localparam logic [7:0]  CRC_INIT      = 8'h00;
  localparam int          CRC_MAX_BITS  = 1024;
  localparam int          CNT_WIDTH     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_crc_accumulator_crc_lfsr_step.sv
// crc_lfsr_step
//   One MSB-first step of an XOR-feedback LFSR CRC. Purely combinational.
//   Ports:
//     crc       in  WIDTH  current CRC register value
//     data_bit  in  1      serial bit being folded in
//     load_init in  1      start the step from INIT instead of crc (first bit of a frame)
//     next_crc  out WIDTH  CRC after absorbing data_bit
module crc_lfsr_step #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = 8'h07,
  parameter logic [WIDTH-1:0] INIT  = 8'h00
) (
  input  logic [WIDTH-1:0] crc,
  input  logic             data_bit,
  input  logic             load_init,
  output logic [WIDTH-1:0] next_crc
);

  logic [WIDTH-1:0] base;
  logic             fb;

  always_comb begin
    base     = load_init ? INIT : crc;
    fb       = base[WIDTH-1] ^ data_bit;
    next_crc = {base[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
  end

endmodule

// File: rtl/serial_crc_accumulator.sv
// serial_crc_accumulator
//   Folds a serial bit stream into a CRC, one accepted bit per cycle, with
//   frames delimited by sof/eof. The completed frame's CRC, bit count and
//   overflow flag are presented on a valid/ready result port.
//   Ports:
//     clk        in   1          rising-edge clock
//     rst_n      in   1          asynchronous active-low reset
//     in_bit     in   1          serial data bit
//     in_valid   in   1          in_bit valid this cycle
//     in_sof     in   1          in_bit is the first bit of a frame
//     in_eof     in   1          in_bit is the last bit of a frame
//     in_ready   out  1          a bit offered this cycle is accepted
//     crc_out    out  WIDTH      CRC of the completed frame
//     bit_count  out  CNT_WIDTH  bits in the completed frame (saturating)
//     frame_err  out  1          completed frame exceeded MAX_BITS
//     out_valid  out  1          result fields valid
//     out_ready  in   1          downstream takes the result
module serial_crc_accumulator
  import serial_crc_accumulator_pkg::*;
#(
  parameter int               WIDTH    = CRC_WIDTH,
  parameter logic [WIDTH-1:0] POLY     = CRC_POLY,
  parameter logic [WIDTH-1:0] INIT     = CRC_INIT,
  parameter int               MAX_BITS = CRC_MAX_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_bit,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic                 in_eof,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     crc_out,
  output logic [CNT_WIDTH-1:0] bit_count,
  output logic                 frame_err,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam logic [31:0] MAX_BITS_W = 32'(MAX_BITS);

  state_t                 state_reg, state_next;
  logic [WIDTH-1:0]       crc_reg, crc_step;
  logic [CNT_WIDTH-1:0]   cnt_reg, cnt_acc;
  logic                   err_reg, err_acc;
  logic                   ready_reg;
  logic [WIDTH-1:0]       crc_out_reg;
  logic [CNT_WIDTH-1:0]   bit_count_reg;
  logic                   frame_err_reg;
  logic                   accept;
  logic                   upd;
  logic                   capture;

  // in_ready is registered from the next state so it is 0 while in reset and
  // drops in the same cycle the FSM enters DONE.
  assign in_ready  = ready_reg;
  assign accept    = in_valid & ready_reg;
  assign out_valid = (state_reg == DONE);
  assign crc_out   = crc_out_reg;
  assign bit_count = bit_count_reg;
  assign frame_err = frame_err_reg & out_valid;

  // A sof bit restarts the LFSR from INIT, whether in IDLE or mid-frame.
  crc_lfsr_step #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .INIT  (INIT)
  ) u_step (
    .crc       (crc_reg),
    .data_bit  (in_bit),
    .load_init (in_sof),
    .next_crc  (crc_step)
  );

  // Counter and overflow flag as they would be after absorbing this bit.
  // "Would exceed MAX_BITS" is cnt+1 > MAX_BITS, i.e. cnt >= MAX_BITS.
  always_comb begin
    cnt_acc = cnt_reg;
    err_acc = err_reg;
    if (in_sof) begin
      cnt_acc = CNT_WIDTH'(1);
      err_acc = (MAX_BITS_W == 32'd0);
    end else begin
      cnt_acc = (cnt_reg == '1) ? cnt_reg : cnt_reg + CNT_WIDTH'(1);
      err_acc = err_reg | (32'(cnt_reg) >= MAX_BITS_W);
    end
  end

  always_comb begin
    state_next = state_reg;
    upd        = 1'b0;
    capture    = 1'b0;
    unique case (state_reg)
      IDLE: begin
        // Bits without sof are dropped here.
        if (accept && in_sof) begin
          upd        = 1'b1;
          capture    = in_eof;
          state_next = in_eof ? DONE : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          upd        = 1'b1;
          capture    = in_eof;
          state_next = in_eof ? DONE : RUN;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ready_reg <= (state_next != DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_reg       <= INIT;
      cnt_reg       <= '0;
      err_reg       <= 1'b0;
      crc_out_reg   <= '0;
      bit_count_reg <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      if (upd) begin
        crc_reg <= crc_step;
        cnt_reg <= cnt_acc;
        err_reg <= err_acc;
      end
      if (capture) begin
        crc_out_reg   <= crc_step;
        bit_count_reg <= cnt_acc;
        frame_err_reg <= err_acc;
      end
    end
  end

endmodule

// File: tb/tb_serial_crc_accumulator.sv
// tb_serial_crc_accumulator
//   Self-checking bench: directed frames from the block's test list plus
//   random frames, each compared against a polynomial long-division model.
module tb_serial_crc_accumulator;
  import serial_crc_accumulator_pkg::*;

  localparam int MAXB = 1024;

  typedef logic bitq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_bit = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic        in_eof = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic [7:0]  crc_out;
  logic [15:0] bit_count;
  logic        frame_err;
  logic        out_valid;

  int vec_count = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_crc_accumulator #(
    .WIDTH    (8),
    .POLY     (CRC_POLY),
    .INIT     (CRC_INIT),
    .MAX_BITS (MAXB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_eof    (in_eof),
    .in_ready  (in_ready),
    .crc_out   (crc_out),
    .bit_count (bit_count),
    .frame_err (frame_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // CRC as the remainder of (M(x)*x^8 + INIT(x)*x^n) divided by x^8+POLY,
  // done as explicit long division over the augmented message.
  function automatic logic [7:0] ref_crc(input bitq_t q);
    logic a[$];
    logic [7:0] poly = CRC_POLY;
    logic [7:0] init = CRC_INIT;
    logic [7:0] r;
    int n = q.size();
    a = q;
    for (int k = 0; k < 8; k++) a.push_back(1'b0);
    for (int k = 0; k < 8; k++) a[k] = a[k] ^ init[7-k];
    for (int i = 0; i < n; i++)
      if (a[i])
        for (int k = 1; k <= 8; k++) a[i+k] = a[i+k] ^ poly[8-k];
    for (int k = 0; k < 8; k++) r[7-k] = a[n+k];
    return r;
  endfunction

  function automatic bitq_t byte_bits(input logic [7:0] b);
    bitq_t q;
    for (int k = 7; k >= 0; k--) q.push_back(b[k]);
    return q;
  endfunction

  function automatic bitq_t rand_bits(input int n);
    bitq_t q;
    for (int k = 0; k < n; k++) q.push_back(1'($urandom_range(0, 1)));
    return q;
  endfunction

  // Called at a negedge; offers one bit, waits (bounded) for in_ready, and
  // returns at the negedge after the accepting posedge.
  task automatic put_bit(input logic b, input logic s, input logic e);
    int guard = 0;
    in_bit = b; in_sof = s; in_eof = e; in_valid = 1'b1;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check_val("ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
    for (int k = 0; k < n; k++) begin
      in_bit = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input bitq_t q, input int gap_max);
    for (int i = 0; i < q.size(); i++) begin
      if (gap_max > 0 && i > 0) idle_cycles($urandom_range(0, gap_max));
      put_bit(q[i], i == 0, i == q.size() - 1);
    end
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
  endtask

  // Called right after the eof bit was accepted: the result must already be valid.
  task automatic get_result(input string tag, input bitq_t q, input int hold);
    logic [7:0]  ec = ref_crc(q);
    int          n  = q.size();
    logic [15:0] en = (n > 65535) ? 16'hFFFF : 16'(n);
    logic        ee = (n > MAXB);
    $display("frame %s: len=%0d crc=%02h cnt=%0d err=%0b (model crc=%02h)",
             tag, n, crc_out, bit_count, frame_err, ec);
    check_val({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_val({tag, "_crc"},   32'(crc_out),   32'(ec));
    check_val({tag, "_cnt"},   32'(bit_count), 32'(en));
    check_val({tag, "_err"},   32'(frame_err), 32'(ee));
    check_val({tag, "_busy"},  32'(in_ready),  32'd0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check_val({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check_val({tag, "_hold_crc"},   32'(crc_out),   32'(ec));
      check_val({tag, "_hold_rdy"},   32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_val({tag, "_released"}, 32'(out_valid), 32'd0);
    check_val({tag, "_idle_rdy"}, 32'(in_ready),  32'd1);
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_crc0"},   32'(crc_out),   32'd0);
    check_val({tag, "_cnt0"},   32'(bit_count), 32'd0);
    check_val({tag, "_err0"},   32'(frame_err), 32'd0);
    check_val({tag, "_valid0"}, 32'(out_valid), 32'd0);
    check_val({tag, "_rdy0"},   32'(in_ready),  32'd0);
  endtask

  initial begin
    bitq_t q, q2;

    // Reset state
    #1;
    check_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val("post_reset_rdy", 32'(in_ready), 32'd1);

    // Bits without sof in IDLE are dropped
    in_valid = 1'b1; in_sof = 1'b0; in_eof = 1'b1; in_bit = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0; in_eof = 1'b0;
    check_val("drop_no_sof", 32'(out_valid), 32'd0);

    // 1. Frame 0x31
    q = byte_bits(8'h31);
    send_frame(q, 0);
    check_val("t1_const", 32'(crc_out), 32'h97);
    get_result("t1", q, 0);

    // 2. One-bit frame
    q = {1'b1};
    send_frame(q, 0);
    check_val("t2_const", 32'(crc_out), 32'h07);
    get_result("t2", q, 0);

    // 3. 0x00 frame held for 5 cycles, with a 1-bit frame offered while busy
    q = byte_bits(8'h00);
    send_frame(q, 1);
    in_bit = 1'b1; in_sof = 1'b1; in_eof = 1'b1; in_valid = 1'b1;
    get_result("t3", q, 5);
    put_bit(1'b1, 1'b1, 1'b1);
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
    q = {1'b1};
    get_result("t3_held_input", q, 0);

    // 4. Abandoned frame: 4 bits of 0xFF, then a fresh 0x31 frame
    for (int i = 0; i < 4; i++) put_bit(1'b1, i == 0, 1'b0);
    check_val("t4_no_early", 32'(out_valid), 32'd0);
    q = byte_bits(8'h31);
    send_frame(q, 0);
    check_val("t4_const", 32'(crc_out), 32'h97);
    check_val("t4_cnt_const", 32'(bit_count), 32'd8);
    get_result("t4", q, 0);
    idle_cycles(3);
    check_val("t4_single", 32'(out_valid), 32'd0);

    // 5. Frame length boundary
    q = rand_bits(MAXB);
    send_frame(q, 0);
    get_result("t5_max", q, 0);
    q = rand_bits(MAXB + 1);
    send_frame(q, 0);
    check_val("t5_err_const", 32'(frame_err), 32'd1);
    get_result("t5_over", q, 1);

    // 6. Reset mid-frame, then a clean frame
    for (int i = 0; i < 3; i++) put_bit(1'b1, i == 0, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero("t6_reset_mid_frame");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    q = byte_bits(8'h31);
    send_frame(q, 0);
    check_val("t6_const", 32'(crc_out), 32'h97);
    get_result("t6", q, 0);

    // Reset while a result is pending
    q = byte_bits(8'hA5);
    send_frame(q, 0);
    check_val("t6b_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_zero("t6b_reset_in_done");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Random frames with gaps, junk between frames and back-pressure
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b1; in_sof = 1'b0; in_eof = 1'($urandom_range(0, 1));
        in_bit = 1'($urandom_range(0, 1));
        @(negedge clk);
        in_valid = 1'b0; in_eof = 1'b0;
      end
      if ($urandom_range(0, 4) == 0) begin
        q2 = rand_bits($urandom_range(1, 6));
        for (int i = 0; i < q2.size(); i++) put_bit(q2[i], i == 0, 1'b0);
      end
      q = rand_bits($urandom_range(1, 40));
      send_frame(q, 2);
      get_result($sformatf("rnd%0d", f), q, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
